// File: rtl/nrzi_pkg.sv
// Shared types and defaults for the NRZI line decoder slice.
package nrzi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int   DATA_W_DEF     = 8;
    localparam int   STUFF_LEN_DEF  = 6;
    localparam logic IDLE_LEVEL_DEF = 1'b1;

    function automatic int ones_cnt_w(input int stuff_len);
        return $clog2(stuff_len + 1);
    endfunction

    localparam int ONES_W_DEF = ones_cnt_w(STUFF_LEN_DEF);

endpackage

// File: rtl/nrzi_bit_unstuffer.sv
// Tracks the run of decoded 1s and classifies each decoded bit as data,
// a dropped stuff bit, or a stuffing violation.
module nrzi_bit_unstuffer
    import nrzi_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic stb,
    input  logic dec,
    output logic bit_stb,
    output logic bit_val,
    output logic err_stb
);

    localparam int OW = ones_cnt_w(STUFF_LEN);

    logic [OW-1:0] ones_cnt_q, ones_cnt_d;
    logic          slot;

    assign slot    = (ones_cnt_q == OW'(STUFF_LEN));
    assign bit_stb = stb & ~slot;
    assign bit_val = dec;
    assign err_stb = stb & slot & dec;

    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (clr) begin
            ones_cnt_d = '0;
        end else if (stb) begin
            // Stuff slot clears the run whether the bit was a proper 0 or a violation.
            if (slot || !dec) ones_cnt_d = '0;
            else              ones_cnt_d = ones_cnt_q + OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ones_cnt_q <= '0;
        else     ones_cnt_q <= ones_cnt_d;
    end

endmodule

// File: rtl/nrzi_line_decoder.sv
// NRZI receive path: level-to-bit decode, bit unstuffing and LSB-first
// word assembly, framed by an IDLE/RUN state machine.
module nrzi_line_decoder
    import nrzi_pkg::*;
#(
    parameter int   DATA_W     = DATA_W_DEF,
    parameter int   STUFF_LEN  = STUFF_LEN_DEF,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame,
    input  logic              din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              stuff_err,
    output logic              busy
);

    localparam int             BW   = $clog2(DATA_W);
    localparam logic [BW-1:0]  LAST = BW'(DATA_W - 1);

    state_t            state_q;
    logic              prev_lvl_q, prev_lvl_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              stuff_err_q, stuff_err_d;

    logic stb, dec, bit_stb, bit_val, err_stb;

    // A strobe in the IDLE->RUN cycle is already live, so gate on frame, not state.
    assign stb = frame & din_valid;
    assign dec = (din == prev_lvl_q);

    nrzi_bit_unstuffer #(
        .STUFF_LEN(STUFF_LEN)
    ) u_unstuff (
        .clk    (clk),
        .rst    (rst),
        .clr    (~frame),
        .stb    (stb),
        .dec    (dec),
        .bit_stb(bit_stb),
        .bit_val(bit_val),
        .err_stb(err_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= frame ? RUN : IDLE;
    end

    always_comb begin
        prev_lvl_d   = prev_lvl_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        if (!frame) begin
            prev_lvl_d = IDLE_LEVEL;
            bit_cnt_d  = '0;
            shift_d    = '0;
        end else if (stb) begin
            prev_lvl_d = din;
            if (err_stb) begin
                stuff_err_d = 1'b1;
                bit_cnt_d   = '0;
                shift_d     = '0;
            end else if (bit_stb) begin
                shift_d = {bit_val, shift_q[DATA_W-1:1]};
                if (bit_cnt_q == LAST) begin
                    bit_cnt_d    = '0;
                    data_out_d   = shift_d;
                    data_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_lvl_q   <= IDLE_LEVEL;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            prev_lvl_q   <= prev_lvl_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign stuff_err  = stuff_err_q;
    assign busy       = (state_q == RUN) && (bit_cnt_q != '0);

endmodule
